// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and sequencer for one shared memory port.
// Latency: ack is MEM_LAT+1 edges after the grant edge; one access per MEM_LAT+3 cycles.
// Backpressure: a losing or waiting requester holds req until its ack; requests are only sampled in IDLE.
// Ports: req/we/addr/wdata per requester in, ack per requester out, rdata registered
// and valid with ack, mem_en/mem_we/mem_addr/mem_wdata to memory, mem_rdata back,
// sel drives the 2:1 datapath mux, busy is high outside IDLE.
module mem_port_arbiter #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int MEM_LAT = 1      // legal 1..7 so MEM_LAT-1 fits the 3-bit wait counter
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              sel,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

   state_t            state_q, state_d;
   logic              last_q, last_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              sel_q, sel_d;
   logic              busy_q, busy_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic              ack0_q, ack0_d;
   logic              ack1_q, ack1_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              winner;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;   // so requester 0 wins the first tie
         cnt_q       <= 3'd0;
         sel_q       <= 1'b0;
         busy_q      <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         busy_q      <= busy_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      sel_d       = sel_q;
      mem_en_d    = mem_en_q;
      mem_we_d    = mem_we_q;
      ack0_d      = ack0_q;
      ack1_d      = ack1_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      // On a tie the requester that did not win last time goes; otherwise the lone requester.
      winner      = (req0 && req1) ? ~last_q : req1;

      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               sel_d       = winner;
               last_d      = winner;
               mem_addr_d  = winner ? addr1  : addr0;
               mem_wdata_d = winner ? wdata1 : wdata0;
               mem_we_d    = winner ? we1    : we0;
               mem_en_d    = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            mem_en_d = 1'b0;
            cnt_d    = CNT_INIT;
            state_d  = WAIT;
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               // Writes leave the previously returned read data in place.
               if (!mem_we_q) begin
                  rdata_d = mem_rdata;
               end
               if (sel_q) begin
                  ack1_d = 1'b1;
               end else begin
                  ack0_d = 1'b1;
               end
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         RESP: begin
            ack0_d  = 1'b0;
            ack1_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign rdata     = rdata_q;
   assign busy      = busy_q;
   assign sel       = sel_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (MEM_LAT 1 and 3) under random requester traffic.
// A transaction-level model predicts each memory access and ack; a monitor pops and compares.
// Includes a reset in the middle of a transaction with requester 0 still pending.
module tb_mem_port_arbiter;
   localparam int DW      = 16;
   localparam int AW      = 16;
   localparam int NTXN    = 30;
   localparam int MAX_CYC = 20000;

   typedef struct {
      int          at;
      logic        sel;
      logic        we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } mem_exp_t;

   typedef struct {
      int            at;
      logic          who;
      logic [DW-1:0] rdata;
   } ack_exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]         req0, req1, we0, we1;
   logic [1:0][AW-1:0] addr0, addr1, mem_addr;
   logic [1:0][DW-1:0] wdata0, wdata1, mem_wdata, mem_rdata, rdata;
   logic [1:0]         ack0, ack1, busy, sel, mem_en, mem_we;

   mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) u_dut_lat1 (
      .clock(clock), .reset(reset),
      .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
      .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
      .ack0(ack0[0]), .ack1(ack1[0]), .rdata(rdata[0]), .busy(busy[0]), .sel(sel[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
   );

   mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(3)) u_dut_lat3 (
      .clock(clock), .reset(reset),
      .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
      .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
      .ack0(ack0[1]), .ack1(ack1[1]), .rdata(rdata[1]), .busy(busy[1]), .sel(sel[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
   );

   function automatic int lat_of(input int l);
      return (l == 0) ? 1 : 3;
   endfunction

   // Contents of never-written memory words; 0x0040 holds the well-known 0xBEEF.
   function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
      return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hC3A5);
   endfunction

   // ---------------- reference model (transaction level) ----------------
   int            edge_n  [2] = '{0, 0};
   int            free_at [2] = '{0, 0};
   int            busy_lo [2] = '{-10, -10};
   int            busy_hi [2] = '{-10, -10};
   logic          m_last  [2] = '{1'b1, 1'b1};
   logic          m_sel   [2] = '{1'b0, 1'b0};
   logic [DW-1:0] m_rdata [2] = '{16'h0, 16'h0};
   logic          pend_wr [2] = '{1'b0, 1'b0};
   logic [16:0]   pend_key[2];
   logic [DW-1:0] pend_dat[2];
   logic [DW-1:0] ref_mem [logic [16:0]];
   mem_exp_t      exp_mem [2][$];
   ack_exp_t      exp_ack [2][$];

   initial begin
      logic          w, wr;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [16:0]   k;
      mem_exp_t      me;
      ack_exp_t      ae;
      forever begin
         @(posedge clock or posedge reset);
         for (int l = 0; l < 2; l++) begin
            if (reset) begin
               free_at[l] = 0;
               busy_lo[l] = -10;
               busy_hi[l] = -10;
               m_last[l]  = 1'b1;
               m_sel[l]   = 1'b0;
               m_rdata[l] = '0;
               pend_wr[l] = 1'b0;
               exp_mem[l].delete();
               exp_ack[l].delete();
            end else begin
               edge_n[l]++;
               // A granted write lands in memory one edge after its grant.
               if (pend_wr[l]) begin
                  ref_mem[pend_key[l]] = pend_dat[l];
                  pend_wr[l] = 1'b0;
               end
               if (edge_n[l] >= free_at[l] && (req0[l] || req1[l])) begin
                  w  = (req0[l] && req1[l]) ? !m_last[l] : req1[l];
                  a  = w ? addr1[l]  : addr0[l];
                  d  = w ? wdata1[l] : wdata0[l];
                  wr = w ? we1[l]    : we0[l];
                  k  = {1'(l), a};
                  m_last[l] = w;
                  m_sel[l]  = w;
                  if (wr) begin
                     pend_wr[l]  = 1'b1;
                     pend_key[l] = k;
                     pend_dat[l] = d;
                  end else begin
                     m_rdata[l] = ref_mem.exists(k) ? ref_mem[k] : init_val(a);
                  end
                  me.at = edge_n[l]; me.sel = w; me.we = wr; me.addr = a; me.wdata = d;
                  exp_mem[l].push_back(me);
                  ae.at = edge_n[l] + 1 + lat_of(l); ae.who = w; ae.rdata = m_rdata[l];
                  exp_ack[l].push_back(ae);
                  free_at[l] = edge_n[l] + 3 + lat_of(l);
                  busy_lo[l] = edge_n[l];
                  busy_hi[l] = edge_n[l] + 1 + lat_of(l);
               end
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int checks = 0;
   int errors = 0;
   bit fin_req = 1'b0;
   bit fin_done = 1'b0;
   bit all_done = 1'b0;
   bit rst_done = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   initial begin
      mem_exp_t me;
      ack_exp_t ae;
      logic     exp_busy;
      forever begin
         @(negedge clock);
         for (int l = 0; l < 2; l++) begin
            if (reset) begin
               chk($sformatf("reset_outputs_l%0d", l),
                   64'({ack0[l], ack1[l], busy[l], sel[l], mem_en[l], mem_we[l],
                         rdata[l], mem_addr[l], mem_wdata[l]}), 64'd0);
            end else begin
               if (mem_en[l]) begin
                  if (exp_mem[l].size() == 0) begin
                     chk($sformatf("unexpected_mem_en_l%0d", l), 64'(mem_en[l]), 64'd0);
                  end else begin
                     me = exp_mem[l].pop_front();
                     chk($sformatf("mem_access_l%0d", l),
                         64'({16'(edge_n[l]), sel[l], mem_we[l], mem_addr[l], mem_wdata[l]}),
                         64'({16'(me.at), me.sel, me.we, me.addr, me.wdata}));
                  end
               end else if (exp_mem[l].size() > 0 && exp_mem[l][0].at < edge_n[l]) begin
                  me = exp_mem[l].pop_front();
                  chk($sformatf("missing_mem_en_l%0d", l), 64'(mem_en[l]), 64'd1);
               end

               if (ack0[l] || ack1[l]) begin
                  if (exp_ack[l].size() == 0) begin
                     chk($sformatf("unexpected_ack_l%0d", l), 64'({ack0[l], ack1[l]}), 64'd0);
                  end else begin
                     ae = exp_ack[l].pop_front();
                     chk($sformatf("ack_l%0d", l),
                         64'({16'(edge_n[l]), ack0[l], ack1[l], rdata[l]}),
                         64'({16'(ae.at), !ae.who, ae.who, ae.rdata}));
                  end
               end else if (exp_ack[l].size() > 0 && exp_ack[l][0].at < edge_n[l]) begin
                  ae = exp_ack[l].pop_front();
                  chk($sformatf("missing_ack_l%0d", l), 64'({ack0[l], ack1[l]}),
                      64'({!ae.who, ae.who}));
               end

               exp_busy = (edge_n[l] >= busy_lo[l]) && (edge_n[l] <= busy_hi[l]);
               chk($sformatf("busy_l%0d", l), 64'(busy[l]), 64'(exp_busy));
               chk($sformatf("sel_l%0d", l), 64'(sel[l]), 64'(m_sel[l]));
            end
         end
         if (fin_req && !fin_done) begin
            chk("all_transactions_acked", 64'(all_done), 64'd1);
            chk("mid_transaction_reset_done", 64'(rst_done), 64'd1);
            chk("expectations_left", 64'(exp_mem[0].size() + exp_mem[1].size() +
                                          exp_ack[0].size() + exp_ack[1].size()), 64'd0);
            fin_done = 1'b1;
         end
      end
   end

   // ---------------- stimulus: requesters, memory device, reset ----------------
   bit            waiting [2][2];
   int            idle_cnt[2][2];
   int            txn_n   [2][2];
   int            dev_due [2] = '{-100, -100};
   logic [DW-1:0] dev_data[2];
   logic [DW-1:0] dev_mem [logic [16:0]];

   function automatic logic get_ack(input int l, input int r);
      return (r == 0) ? ack0[l] : ack1[l];
   endfunction

   task automatic drive(input int l, input int r, input logic rq, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (r == 0) begin
         req0[l] = rq; we0[l] = wr; addr0[l] = a; wdata0[l] = d;
      end else begin
         req1[l] = rq; we1[l] = wr; addr1[l] = a; wdata1[l] = d;
      end
   endtask

   task automatic issue(input int l, input int r);
      if (txn_n[l][r] == 0 && r == 0) begin
         drive(l, r, 1'b1, 1'b0, 16'h0040, 16'h0000);
      end else if (txn_n[l][r] == 0) begin
         drive(l, r, 1'b1, 1'b1, 16'h0100, 16'h1234);
      end else begin
         drive(l, r, 1'b1, 1'($urandom_range(0, 1)),
               16'h0040 * 16'($urandom_range(1, 8)), 16'($urandom));
      end
      waiting[l][r] = 1'b1;
   endtask

   task automatic step_req(input int l, input int r);
      if (waiting[l][r]) begin
         if (get_ack(l, r)) begin
            waiting[l][r] = 1'b0;
            txn_n[l][r]++;
            if (txn_n[l][r] < NTXN && (txn_n[l][r] < 4 || $urandom_range(0, 2) == 0)) begin
               issue(l, r);   // back-to-back: req stays high into the next IDLE
            end else begin
               drive(l, r, 1'b0, 1'b0, '0, '0);
               idle_cnt[l][r] = $urandom_range(0, 5);
            end
         end
      end else if (txn_n[l][r] < NTXN) begin
         if (idle_cnt[l][r] == 0) begin
            issue(l, r);
         end else begin
            idle_cnt[l][r]--;
         end
      end
   endtask

   // Memory device: writes commit when sampled, read data appears only in the
   // cycle before the capture edge; other cycles carry noise.
   task automatic mem_device(input int l);
      logic [16:0] k;
      if (dev_due[l] == edge_n[l]) begin
         mem_rdata[l] = dev_data[l];
      end else begin
         mem_rdata[l] = 16'($urandom);
      end
      if (mem_en[l]) begin
         k = {1'(l), mem_addr[l]};
         if (mem_we[l]) begin
            dev_mem[k] = mem_wdata[l];
         end else begin
            dev_due[l]  = edge_n[l] + lat_of(l);
            dev_data[l] = dev_mem.exists(k) ? dev_mem[k] : init_val(mem_addr[l]);
         end
      end
   endtask

   initial begin
      int cyc;
      int rst_hold;
      bit done_all;
      for (int l = 0; l < 2; l++) begin
         for (int r = 0; r < 2; r++) begin
            drive(l, r, 1'b0, 1'b0, '0, '0);
            waiting[l][r]  = 1'b0;
            txn_n[l][r]    = 0;
            idle_cnt[l][r] = (r == 0) ? 0 : 8;
         end
         mem_rdata[l] = '0;
      end
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;

      cyc      = 0;
      rst_hold = 0;
      while (!(all_done && rst_done) && cyc < MAX_CYC) begin
         @(negedge clock);
         cyc++;
         for (int l = 0; l < 2; l++) mem_device(l);
         for (int l = 0; l < 2; l++) begin
            for (int r = 0; r < 2; r++) step_req(l, r);
         end
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) reset = 1'b0;
         end else if (!rst_done && !reset && cyc > 150 && waiting[0][0] &&
                      m_last[0] == 1'b0 && edge_n[0] == busy_lo[0]) begin
            // Lane 0 is in ISSUE for requester 0; hit reset just after it enters WAIT.
            @(posedge clock);
            #1;
            reset      = 1'b1;
            dev_due[0] = -100;
            dev_due[1] = -100;
            rst_hold   = 3;
            rst_done   = 1'b1;
         end
         done_all = 1'b1;
         for (int l = 0; l < 2; l++) begin
            for (int r = 0; r < 2; r++) begin
               if (txn_n[l][r] < NTXN) done_all = 1'b0;
            end
         end
         all_done = done_all;
      end

      repeat (20) begin
         @(negedge clock);
         for (int l = 0; l < 2; l++) mem_device(l);
      end
      fin_req = 1'b1;
      for (int i = 0; i < 10 && !fin_done; i++) @(negedge clock);
      if (!fin_done) begin
         $display("FAIL final_checks_timeout actual=0 expected=1");
         $fatal(1, "final checks did not run");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
